register_file_2r1w: RTL and testbench

- 32 x 32-bit integer register file for the RV32I datapath. One synchronous write port, two combinational read ports.
- Write side is the inverse of the operand-select muxes: a one-hot 5-to-32 decode steers write data into exactly one register per cycle.
- Read data feeds the ALU-input muxes. Write data comes from the writeback-select mux.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/register_file_2r1w_decoder_5x32.sv | 17 +
 rtl/register_file_2r1w.sv | 69 ++++++
 tb/tb_register_file_2r1w.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I datapath constants and types.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int ADDR_W    = 5;
    localparam int REG_COUNT = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   word_t;

endpackage

// File: rtl/register_file_2r1w_decoder_5x32.sv
// One-hot 5-to-32 decoder producing per-register write enables.
module decoder_5x32
    import riscv_pkg::*;
(
    input  reg_addr_t              A,
    input  logic                   EN,
    output logic [REG_COUNT-1:0]   Y
);

    always_comb begin
        Y = '0;
        if (EN) begin
            Y = REG_COUNT'(1) << A;
        end
    end

endmodule

// File: rtl/register_file_2r1w.sv
// 32 x XLEN register file: one synchronous write port, two combinational
// read ports, x0 hardwired to zero, optional same-cycle write-through.
module register_file_2r1w #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int ADDR_W    = 5,
    parameter int BYPASS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WE,
    input  logic [ADDR_W-1:0] RD,
    input  logic [XLEN-1:0]   WD,
    input  logic [ADDR_W-1:0] RS1,
    input  logic [ADDR_W-1:0] RS2,
    output logic [XLEN-1:0]   RD1,
    output logic [XLEN-1:0]   RD2
);

    import riscv_pkg::*;

    logic [XLEN-1:0]      r_regs [REG_COUNT];
    logic [REG_COUNT-1:0] w_we_onehot;
    logic                 w_fwd1;
    logic                 w_fwd2;

    decoder_5x32 u_decoder (
        .A  (RD),
        .EN (WE),
        .Y  (w_we_onehot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            // Enable bit 0 is ignored so x0 never holds anything but zero.
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                if (w_we_onehot[i] && (i != 0)) begin
                    r_regs[i] <= WD;
                end
            end
        end
    end

    always_comb begin
        w_fwd1 = (BYPASS != 0) && WE && !reset && (RD == RS1);
        w_fwd2 = (BYPASS != 0) && WE && !reset && (RD == RS2);

        if (RS1 == ZERO_REG) begin
            RD1 = '0;
        end else if (w_fwd1) begin
            RD1 = WD;
        end else begin
            RD1 = r_regs[RS1];
        end

        if (RS2 == ZERO_REG) begin
            RD2 = '0;
        end else if (w_fwd2) begin
            RD2 = WD;
        end else begin
            RD2 = r_regs[RS2];
        end
    end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking bench: BYPASS=1 and BYPASS=0 instances share stimulus and are
// compared against constant vectors and an array-based reference model.
module tb_register_file_2r1w;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [4:0]  RD;
    logic [31:0] WD;
    logic [4:0]  RS1;
    logic [4:0]  RS2;
    logic [31:0] RD1_b, RD2_b, RD1_n, RD2_n;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem [32];

    register_file_2r1w #(.XLEN(32), .REG_COUNT(32), .ADDR_W(5), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .WE(WE), .RD(RD), .WD(WD),
        .RS1(RS1), .RS2(RS2), .RD1(RD1_b), .RD2(RD2_b)
    );

    register_file_2r1w #(.XLEN(32), .REG_COUNT(32), .ADDR_W(5), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .WE(WE), .RD(RD), .WD(WD),
        .RS1(RS1), .RS2(RS2), .RD1(RD1_n), .RD2(RD2_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e1_b;
        logic [31:0] e2_b;
        logic [31:0] e1_n;
        logic [31:0] e2_n;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Architectural view: x0 reads zero, write-through only when bypass is on
    // and reset is low, otherwise the stored value.
    function automatic logic [31:0] model_rd(input logic [4:0] rs, input bit byp);
        if (rs == 5'd0) return 32'd0;
        if (byp && WE && !reset && (RD == rs)) return WD;
        return mem[rs];
    endfunction

    task automatic drive(input bit rst, input bit we, input logic [4:0] rd,
                         input logic [31:0] wd, input logic [4:0] rs1, input logic [4:0] rs2);
        reset = rst; WE = we; RD = rd; WD = wd; RS1 = rs1; RS2 = rs2;
        #1;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        end else if (WE && (RD != 5'd0)) begin
            mem[RD] = WD;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " RD1 bypass"},   RD1_b, model_rd(RS1, 1'b1));
        chk({tag, " RD2 bypass"},   RD2_b, model_rd(RS2, 1'b1));
        chk({tag, " RD1 nobypass"}, RD1_n, model_rd(RS1, 1'b0));
        chk({tag, " RD2 nobypass"}, RD2_n, model_rd(RS2, 1'b0));
    endtask

    vec_t vecs [14];
    int   errs_before;

    initial begin
        vecs[0]  = '{0,0,5'd0, 32'h0,        5'd5, 5'd31, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[1]  = '{0,1,5'd5, 32'hDEADBEEF, 5'd5, 5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
        vecs[2]  = '{1,1,5'd7, 32'h1,        5'd5, 5'd7,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[3]  = '{0,0,5'd0, 32'h0,        5'd5, 5'd7,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[4]  = '{0,1,5'd3, 32'd42,       5'd3, 5'd3,  32'd42,       32'd42,       32'h0,        32'h0};
        vecs[5]  = '{0,1,5'd31,32'hFFFFFFFF, 5'd3, 5'd31, 32'd42,       32'hFFFFFFFF, 32'd42,       32'h0};
        vecs[6]  = '{0,1,5'd0, 32'h12345678, 5'd0, 5'd31, 32'h0,        32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF};
        vecs[7]  = '{0,0,5'd0, 32'h0,        5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[8]  = '{0,1,5'd9, 32'd1,        5'd9, 5'd3,  32'd1,        32'd42,       32'h0,        32'd42};
        vecs[9]  = '{0,1,5'd9, 32'd2,        5'd9, 5'd9,  32'd2,        32'd2,        32'd1,        32'd1};
        vecs[10] = '{0,0,5'd0, 32'h0,        5'd9, 5'd9,  32'd2,        32'd2,        32'd2,        32'd2};
        vecs[11] = '{0,1,5'd12,32'd10,       5'd12,5'd9,  32'd10,       32'd2,        32'h0,        32'd2};
        vecs[12] = '{0,1,5'd12,32'd20,       5'd12,5'd12, 32'd20,       32'd20,       32'd10,       32'd10};
        vecs[13] = '{0,0,5'd0, 32'h0,        5'd12,5'd3,  32'd20,       32'd42,       32'd20,       32'd42};

        // Power-up contents are undefined; clear with one reset edge first.
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        clock_edge();

        for (int v = 0; v < 14; v++) begin
            drive(vecs[v].rst, vecs[v].we, vecs[v].rd, vecs[v].wd, vecs[v].rs1, vecs[v].rs2);
            chk($sformatf("vec%0d RD1 bypass", v),   RD1_b, vecs[v].e1_b);
            chk($sformatf("vec%0d RD2 bypass", v),   RD2_b, vecs[v].e2_b);
            chk($sformatf("vec%0d RD1 nobypass", v), RD1_n, vecs[v].e1_n);
            chk($sformatf("vec%0d RD2 nobypass", v), RD2_n, vecs[v].e2_n);
            clock_edge();
        end

        // Fill x1..x31 with i*3, then sweep the ports in opposite directions.
        errs_before = n_checks - n_pass;
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b1, 5'(i), 32'(i * 3), 5'(i), 5'(32 - i));
            check_model($sformatf("fill%0d", i));
            clock_edge();
        end
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            chk($sformatf("sweep%0d RD1 bypass", i),   RD1_b, 32'(i * 3));
            chk($sformatf("sweep%0d RD2 bypass", i),   RD2_b, 32'((31 - i) * 3));
            chk($sformatf("sweep%0d RD1 nobypass", i), RD1_n, 32'(i * 3));
            chk($sformatf("sweep%0d RD2 nobypass", i), RD2_n, 32'((31 - i) * 3));
            clock_edge();
        end
        $display("Errors: %0d", (n_checks - n_pass) - errs_before);

        for (int k = 0; k < 2000; k++) begin
            logic [4:0] rd_r, rs1_r, rs2_r;
            rd_r  = 5'($urandom());
            rs1_r = ($urandom_range(0, 2) == 0) ? rd_r : 5'($urandom());
            rs2_r = ($urandom_range(0, 2) == 0) ? rd_r : 5'($urandom());
            drive(($urandom_range(0, 49) == 0), 1'($urandom()), rd_r, $urandom(), rs1_r, rs2_r);
            check_model($sformatf("rand%0d", k));
            clock_edge();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
